sdram_demo_pll_reset_ctrl: RTL

//  Drives the system PLL's rst input and consumes its locked output. Sequences PLL reset, qualifies lock,
//  and releases a synchronous system reset to the Nios II / SDRAM controller domain only after stable lock.

---
 rtl/sdram_demo_pll_reset_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_demo_pll_reset_ctrl.sv
// sdram_demo_pll_reset_ctrl
//   Sequences the system PLL reset, qualifies lock, and releases a synchronous
//   system reset to the Nios II / SDRAM controller domain once lock is stable.
//   Recovers from lock loss in RUN and from lock timeouts; after MAX_RETRIES
//   consecutive timeouts it parks in FAIL until rst.
//   Optional build macro: PLL_RST_CTRL_LOSS_FILTER_EN
//     defined   - a lock loss in RUN is lk low for 4 consecutive cycles
//     undefined - a single cycle of lk low in RUN is a lock loss
module sdram_demo_pll_reset_ctrl #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       err,
  output logic [7:0] relock_count
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned RET_W   = $clog2(MAX_RETRIES) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RET_W-1:0] RETRY_LIMIT  = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retries_q, retries_d;
  logic [7:0]       relock_q, relock_d;
  logic             sync1_q, lk_q;
  logic             pll_rst_q, sys_rst_q, ready_q, err_q;
  logic             loss_event;

`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
  logic [2:0]       filt_q, filt_d;
`endif

  // Lock-loss detection while in RUN; filtered build needs 4 consecutive low cycles
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
  always_comb begin
    filt_d     = filt_q;
    loss_event = 1'b0;
    if (state_q == S_RUN) begin
      if (lk_q) begin
        filt_d = 3'd0;
      end else if (filt_q == 3'd3) begin
        loss_event = 1'b1;
        filt_d     = 3'd0;
      end else begin
        filt_d = filt_q + 3'd1;
      end
    end else if (state_d == S_RUN) begin
      filt_d = 3'd0;
    end
  end
`else
  always_comb begin
    loss_event = (state_q == S_RUN) && !lk_q;
  end
`endif

  // Next-state, counter, retry and relock bookkeeping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lk_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_q + RET_W'(1);
          cnt_d     = '0;
          if ((retries_q + RET_W'(1)) == RETRY_LIMIT) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // lk is checked before the count so a drop on the final cycle still aborts
        if (!lk_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (loss_event) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
          end
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State, synchronizer and registered outputs (outputs follow the next state)
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retries_q <= '0;
      relock_q  <= 8'd0;
      sync1_q   <= 1'b0;
      lk_q      <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
      filt_q    <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      relock_q  <= relock_d;
      sync1_q   <= pll_locked;
      lk_q      <= sync1_q;
      pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      err_q     <= (state_d == S_FAIL);
`ifdef PLL_RST_CTRL_LOSS_FILTER_EN
      filt_q    <= filt_d;
`endif
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign ready        = ready_q;
  assign err          = err_q;
  assign relock_count = relock_q;

endmodule
